hazard_det: RTL and testbench
=============================

HAZARD_DET -- requirements
Module: hazard_det

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; rising edge active.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port fetch_inst, input, 16 bits: raw instruction word from instruction memory.
REQ-004 SHALL have ports regWrtD/regWrtX/regWrtM/regWrtW, inputs, 1 bit each: the instruction in that stage writes the register file.
REQ-005 SHALL have ports wrtRegD/wrtRegX/wrtRegM/wrtRegW, inputs, 3 bits each: destination register of that stage.
REQ-006 SHALL have ports branchInstD/branchInstX/branchInstM/branchInstW, inputs, 1 bit each: a control-transfer instruction occupies that stage.
REQ-007 SHALL have port next_inst, output, 16 bits: instruction issued to decode.
REQ-008 SHALL have port pcNop, output, 1 bit: hold PC (1 = do not advance).
REQ-009 SHALL have port branchInstF, output, 1 bit: the issued next_inst is a control transfer.

Function
REQ-010 SHALL decode opcode = fetch_inst[15:11], Rs = [10:8], Rt = [7:5].
REQ-011 SHALL treat NOP as 16'h0800 (opcode 00001) and HALT as opcode 00000.
REQ-012 SHALL mark Rs as used for opcodes 010xx, 101xx, 10000, 10001, 10010, 10011, 11001, 11010, 11011, 111xx, 011xx, 00101, 00111.
REQ-013 SHALL mark Rt as used for opcodes 11010, 11011, 111xx, 10000 and 10011 (store data).
REQ-014 SHALL mark no source as used for 00000, 00001, 00010, 00011, 00100, 00110 and 11000.
REQ-015 SHALL assert RAW hazard when, for any stage S in {D,X,M,W}, regWrtS = 1 and wrtRegS equals a used source register; W is included because there is no register-file bypass.
REQ-016 SHALL assert branch-pending when branchInstD, branchInstX or branchInstM = 1.
REQ-017 SHALL, on RAW hazard or branch-pending, drive next_inst = NOP and pcNop = 1, both combinationally in the same cycle.
REQ-018 SHALL, when branchInstW = 1 and there is no RAW hazard, pass fetch_inst and drive pcNop = 0; the fetch logic loads the redirect PC.
REQ-019 SHALL otherwise drive next_inst = fetch_inst and pcNop = 0.
REQ-020 SHALL drive branchInstF = 1 only when next_inst = fetch_inst and the opcode is 011xx or 001xx (J, JR, JAL, JALR).
REQ-021 SHALL hold one register, halted, set at the clock edge on which a HALT is issued (next_inst = HALT word).
REQ-022 SHALL, while halted = 1, drive next_inst = NOP, pcNop = 1 and branchInstF = 0 regardless of other inputs.
REQ-023 SHALL give RAW and branch-pending stalls priority over HALT issue; a stalled HALT does not set halted.
REQ-024 SHALL need no inputs other than those in REQ-001 to REQ-006; all outputs except halted have zero-cycle latency.

Reset
REQ-025 SHALL clear halted asynchronously when rst = 0.
REQ-026 SHALL, while rst = 0, drive next_inst = NOP, pcNop = 0 and branchInstF = 0.
REQ-027 SHALL treat reset mid-stall or mid-halt as aborting it; normal issue resumes on the first cycle with rst = 1.

Structure
REQ-028 SHALL place opcode constants, the NOP word and the HALT opcode in a shared package, wisc_isa_pkg.
REQ-029 SHALL implement source-use decoding (REQ-012 to REQ-014) in one sub-module, hazard_src_decode, with input opcode and outputs rs_used and rt_used.

Verification
REQ-030 SHALL cover this RAW case: fetch_inst = 16'hDA20 (ADD, Rs = 2, Rt = 1), regWrtX = 1, wrtRegX = 1 -> next_inst = 16'h0800, pcNop = 1; then regWrtX = 0 -> next_inst = 16'hDA20, pcNop = 0.
REQ-031 SHALL cover this false hazard: fetch_inst = LBI (opcode 11000), regWrtD = 1, wrtRegD = Rs field -> no stall, pcNop = 0.
REQ-032 SHALL cover this branch case: fetch_inst = BEQZ (opcode 01100) -> branchInstF = 1; then branchInstD, X and M set in turn -> NOP and pcNop = 1 each cycle; then branchInstW = 1 -> pass-through, pcNop = 0.
REQ-033 SHALL cover this halt case: issue 16'h0000 -> halted sets; any later fetch_inst -> NOP, pcNop = 1 until rst = 0.
REQ-034 SHALL cover this async reset: drop rst between clock edges while halted -> halted clears immediately, next_inst = NOP, pcNop = 0.
REQ-035 SHALL cover this store-data case: fetch_inst = ST (opcode 10000) with [7:5] = 3, regWrtW = 1, wrtRegW = 3 -> stall.

Source files
------------

// File: rtl/wisc_isa_pkg.sv
// Shared ISA constants for the WISC pipeline: opcode values, the NOP word
// and the control-transfer classification used by the hazard logic.
package wisc_isa_pkg;

  localparam int unsigned INST_W = 16;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned REG_W  = 3;

  localparam logic [OP_W-1:0] OP_HALT = 5'b00000;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b00001;
  localparam logic [OP_W-1:0] OP_J    = 5'b00100;
  localparam logic [OP_W-1:0] OP_JR   = 5'b00101;
  localparam logic [OP_W-1:0] OP_JAL  = 5'b00110;
  localparam logic [OP_W-1:0] OP_JALR = 5'b00111;
  localparam logic [OP_W-1:0] OP_BEQZ = 5'b01100;
  localparam logic [OP_W-1:0] OP_ST   = 5'b10000;
  localparam logic [OP_W-1:0] OP_STU  = 5'b10011;
  localparam logic [OP_W-1:0] OP_LBI  = 5'b11000;

  localparam logic [INST_W-1:0] NOP_WORD = 16'h0800;

  // Branches (011xx) and jumps (001xx) redirect the PC.
  function automatic logic is_ctrl_xfer(input logic [OP_W-1:0] op);
    return (op[4:2] == 3'b011) || (op[4:2] == 3'b001);
  endfunction

endpackage

// File: rtl/hazard_src_decode.sv
// Source-operand use decode: which of the Rs / Rt fields an opcode reads.
module hazard_src_decode
  import wisc_isa_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output logic            rs_used,
  output logic            rt_used
);

  // Rs is read by ALU, immediate, memory, branch and register-jump ops.
  always_comb begin
    rs_used = 1'b0;
    casez (opcode)
      5'b010??, 5'b100??, 5'b101??, 5'b11001, 5'b11010, 5'b11011,
      5'b111??, 5'b011??, OP_JR, OP_JALR: rs_used = 1'b1;
      default:                            rs_used = 1'b0;
    endcase
  end

  // Rt is read by register-register ALU ops and as store data.
  always_comb begin
    rt_used = 1'b0;
    casez (opcode)
      5'b11010, 5'b11011, 5'b111??, OP_ST, OP_STU: rt_used = 1'b1;
      default:                                     rt_used = 1'b0;
    endcase
  end

endmodule

// File: rtl/hazard_det.sv
// Issue-stage hazard detector: stalls fetch on RAW dependences against any
// in-flight writer (no register-file bypass) or while a control transfer is
// unresolved, and freezes issue permanently once a HALT has been issued.
module hazard_det
  import wisc_isa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] fetch_inst,
  input  logic              regWrtD,
  input  logic              regWrtX,
  input  logic              regWrtM,
  input  logic              regWrtW,
  input  logic [REG_W-1:0]  wrtRegD,
  input  logic [REG_W-1:0]  wrtRegX,
  input  logic [REG_W-1:0]  wrtRegM,
  input  logic [REG_W-1:0]  wrtRegW,
  input  logic              branchInstD,
  input  logic              branchInstX,
  input  logic              branchInstM,
  input  logic              branchInstW,
  output logic [INST_W-1:0] next_inst,
  output logic              pcNop,
  output logic              branchInstF
);

  logic [OP_W-1:0]  opcode;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic             rs_used;
  logic             rt_used;
  logic             rs_hit;
  logic             rt_hit;
  logic             raw_haz;
  logic             br_pend;
  logic             stall;
  logic             halted_q;
  logic             halted_d;

  assign opcode = fetch_inst[15:11];
  assign rs     = fetch_inst[10:8];
  assign rt     = fetch_inst[7:5];

  hazard_src_decode u_src_decode (
    .opcode  (opcode),
    .rs_used (rs_used),
    .rt_used (rt_used)
  );

  // RAW detection against every writing stage, W included.
  always_comb begin
    rs_hit = (regWrtD && (wrtRegD == rs)) || (regWrtX && (wrtRegX == rs)) ||
             (regWrtM && (wrtRegM == rs)) || (regWrtW && (wrtRegW == rs));
    rt_hit = (regWrtD && (wrtRegD == rt)) || (regWrtX && (wrtRegX == rt)) ||
             (regWrtM && (wrtRegM == rt)) || (regWrtW && (wrtRegW == rt));
    raw_haz = (rs_used && rs_hit) || (rt_used && rt_hit);
    // A transfer in W has resolved; fetch is already loading its target.
    br_pend = branchInstD || branchInstX || branchInstM;
    stall   = raw_haz || br_pend;
  end

  // Issue mux; reset and halt override everything, stall overrides issue.
  always_comb begin
    next_inst   = NOP_WORD;
    pcNop       = 1'b0;
    branchInstF = 1'b0;
    halted_d    = halted_q;
    if (!rst) begin
      next_inst = NOP_WORD;
      pcNop     = 1'b0;
    end else if (halted_q) begin
      next_inst = NOP_WORD;
      pcNop     = 1'b1;
    end else if (stall) begin
      next_inst = NOP_WORD;
      pcNop     = 1'b1;
    end else begin
      next_inst   = fetch_inst;
      pcNop       = 1'b0;
      branchInstF = is_ctrl_xfer(opcode);
      halted_d    = (opcode == OP_HALT);
    end
  end

  // Halt latch: set when a HALT actually issues, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) halted_q <= 1'b0;
    else      halted_q <= halted_d;
  end

endmodule

// File: tb/tb_hazard_det.sv
// Directed bench for hazard_det: a driver applies one vector per cycle and
// queues its hand-computed response; a monitor on the falling edge pops and
// compares against the DUT outputs.
module tb_hazard_det;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk;
  logic        rst;
  logic [15:0] fetch_inst;
  logic        regWrtD, regWrtX, regWrtM, regWrtW;
  logic [2:0]  wrtRegD, wrtRegX, wrtRegM, wrtRegW;
  logic        branchInstD, branchInstX, branchInstM, branchInstW;
  logic [15:0] next_inst;
  logic        pcNop;
  logic        branchInstF;

  logic [17:0] exp_q[$];
  string       name_q[$];
  logic        pending;
  int          checks;
  int          failures;

  hazard_det dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_inst  (fetch_inst),
    .regWrtD     (regWrtD),
    .regWrtX     (regWrtX),
    .regWrtM     (regWrtM),
    .regWrtW     (regWrtW),
    .wrtRegD     (wrtRegD),
    .wrtRegX     (wrtRegX),
    .wrtRegM     (wrtRegM),
    .wrtRegW     (wrtRegW),
    .branchInstD (branchInstD),
    .branchInstX (branchInstX),
    .branchInstM (branchInstM),
    .branchInstW (branchInstW),
    .next_inst   (next_inst),
    .pcNop       (pcNop),
    .branchInstF (branchInstF)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] ex(input logic [15:0] ni, input logic pc,
                                     input logic bf);
    return {ni, pc, bf};
  endfunction

  // Apply a vector now and wait until the monitor has checked it.
  // rw = {D,X,M,W} write enables, wr = {D,X,M,W} destinations, br = {D,X,M,W}.
  task automatic apply_now(input string nm, input logic [15:0] inst,
                           input logic [3:0] rw, input logic [11:0] wr,
                           input logic [3:0] br, input logic [17:0] e);
    fetch_inst = inst;
    {regWrtD, regWrtX, regWrtM, regWrtW} = rw;
    {wrtRegD, wrtRegX, wrtRegM, wrtRegW} = wr;
    {branchInstD, branchInstX, branchInstM, branchInstW} = br;
    exp_q.push_back(e);
    name_q.push_back(nm);
    pending = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic step(input string nm, input logic [15:0] inst,
                      input logic [3:0] rw, input logic [11:0] wr,
                      input logic [3:0] br, input logic [17:0] e);
    @(posedge clk);
    #1;
    apply_now(nm, inst, rw, wr, br, e);
  endtask

  // Scoreboard monitor
  initial begin
    logic [17:0] e;
    logic [17:0] act;
    string       nm;
    forever begin
      @(negedge clk);
      if (pending) begin
        pending = 1'b0;
        act = {next_inst, pcNop, branchInstF};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s: no expected entry, got %h", "queue", act);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL %s: got next_inst=%h pcNop=%b brF=%b, want next_inst=%h pcNop=%b brF=%b",
                     nm, act[17:2], act[1], act[0], e[17:2], e[1], e[0]);
          end
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    checks   = 0;
    failures = 0;
    pending  = 1'b0;
    rst      = 1'b0;
    fetch_inst = 16'h0000;
    {regWrtD, regWrtX, regWrtM, regWrtW} = 4'b0;
    {wrtRegD, wrtRegX, wrtRegM, wrtRegW} = 12'b0;
    {branchInstD, branchInstX, branchInstM, branchInstW} = 4'b0;

    step("reset_out", 16'hDA20, 4'b0000, 12'h000, 4'b0000, ex(NOP, 1'b0, 1'b0));
    @(posedge clk);
    #1 rst = 1'b1;

    // RAW on Rt in X, then released
    apply_now("raw_x_rt", 16'hDA20, 4'b0100, {3'd0, 3'd1, 3'd0, 3'd0}, 4'b0000, ex(NOP, 1'b1, 1'b0));
    step("raw_clear", 16'hDA20, 4'b0000, {3'd0, 3'd1, 3'd0, 3'd0}, 4'b0000, ex(16'hDA20, 1'b0, 1'b0));
    // LBI reads nothing: no false hazard
    step("lbi_nohaz", 16'hC503, 4'b1000, {3'd5, 3'd0, 3'd0, 3'd0}, 4'b0000, ex(16'hC503, 1'b0, 1'b0));
    // Branch walks down the pipe
    step("beqz_issue", 16'h6100, 4'b0000, 12'h000, 4'b0000, ex(16'h6100, 1'b0, 1'b1));
    step("br_in_d", 16'hC503, 4'b0000, 12'h000, 4'b1000, ex(NOP, 1'b1, 1'b0));
    step("br_in_x", 16'hC503, 4'b0000, 12'h000, 4'b0100, ex(NOP, 1'b1, 1'b0));
    step("br_in_m", 16'hC503, 4'b0000, 12'h000, 4'b0010, ex(NOP, 1'b1, 1'b0));
    step("br_in_w", 16'hC503, 4'b0000, 12'h000, 4'b0001, ex(16'hC503, 1'b0, 1'b0));
    step("br_w_raw", 16'hDA20, 4'b0010, {3'd0, 3'd0, 3'd2, 3'd0}, 4'b0001, ex(NOP, 1'b1, 1'b0));
    // Store data (Rt) hazard from W, and the same without a write enable
    step("st_rt_w", 16'h8260, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd3}, 4'b0000, ex(NOP, 1'b1, 1'b0));
    step("st_no_wen", 16'h8260, 4'b0000, {3'd0, 3'd0, 3'd0, 3'd3}, 4'b0000, ex(16'h8260, 1'b0, 1'b0));
    step("jr_rs_m", 16'h2C00, 4'b0010, {3'd0, 3'd0, 3'd4, 3'd0}, 4'b0000, ex(NOP, 1'b1, 1'b0));
    step("jr_issue", 16'h2C00, 4'b0000, 12'h000, 4'b0000, ex(16'h2C00, 1'b0, 1'b1));
    step("j_no_src", 16'h2000, 4'b1000, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000, ex(16'h2000, 1'b0, 1'b1));
    step("addi_rs_m", 16'h4600, 4'b0010, {3'd0, 3'd0, 3'd6, 3'd0}, 4'b0000, ex(NOP, 1'b1, 1'b0));
    step("rol_rt_unused", 16'hA1E0, 4'b0100, {3'd0, 3'd7, 3'd0, 3'd0}, 4'b0000, ex(16'hA1E0, 1'b0, 1'b0));
    // A stalled HALT must not latch
    step("halt_stalled", 16'h0000, 4'b0000, 12'h000, 4'b0100, ex(NOP, 1'b1, 1'b0));
    step("after_stalled_halt", 16'hDA20, 4'b0000, 12'h000, 4'b0000, ex(16'hDA20, 1'b0, 1'b0));
    // Issued HALT latches
    step("halt_issue", 16'h0000, 4'b0000, 12'h000, 4'b0000, ex(16'h0000, 1'b0, 1'b0));
    step("halted_add", 16'hDA20, 4'b0000, 12'h000, 4'b0000, ex(NOP, 1'b1, 1'b0));
    step("halted_br_w", 16'h6100, 4'b0000, 12'h000, 4'b0001, ex(NOP, 1'b1, 1'b0));
    // Async reset between edges while halted, released before the next edge
    @(posedge clk);
    #1 rst = 1'b0;
    apply_now("async_rst", 16'hDA20, 4'b0000, 12'h000, 4'b0000, ex(NOP, 1'b0, 1'b0));
    rst = 1'b1;
    apply_now("resume_after_rst", 16'hDA20, 4'b0000, 12'h000, 4'b0000, ex(16'hDA20, 1'b0, 1'b0));

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: %0d unchecked entries, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
